// File: rtl/pressure_sequencer.sv
// Pressure change sequencer: ramps a modelled chamber level, then pulses the toggle
// key for limit_pressure and waits for limit to flip as acknowledgement.
module pressure_sequencer #(
  parameter int RAMP_CYCLES = 8,
  parameter int CNT_W       = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             change_req,
  input  logic             abort,
  input  logic             limit,
  output logic             key,
  output logic             busy,
  output logic             dir,
  output logic [CNT_W-1:0] level,
  output logic             err
);

  localparam int ACK_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LVL_MAX  = CNT_W'(RAMP_CYCLES);
  localparam logic [CNT_W-1:0] LVL_ZERO = '0;
  localparam logic [CNT_W-1:0] LVL_ONE  = CNT_W'(1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [ACK_W-1:0] ACK_ONE  = ACK_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP,
    S_PULSE,
    S_WAIT_ACK,
    S_RETURN
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] level_next;
  logic             dir_next, err_next;
  logic             start_limit, start_next;
  logic [ACK_W-1:0] ack_cnt, ack_next;
  logic [CNT_W-1:0] start_level, ramp_end;

  assign start_level = start_limit ? LVL_MAX : LVL_ZERO;
  assign ramp_end    = dir ? LVL_MAX : LVL_ZERO;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      level       <= '0;
      dir         <= 1'b0;
      err         <= 1'b0;
      start_limit <= 1'b0;
      ack_cnt     <= '0;
    end else begin
      state       <= state_next;
      level       <= level_next;
      dir         <= dir_next;
      err         <= err_next;
      start_limit <= start_next;
      ack_cnt     <= ack_next;
    end
  end

  // Abort wins over stepping in RAMP; RETURN compares against the start level
  // before stepping so an abort on the first ramp edge exits after one edge.
  always_comb begin
    state_next = state;
    level_next = level;
    dir_next   = dir;
    err_next   = err;
    start_next = start_limit;
    ack_next   = ack_cnt;
    case (state)
      S_IDLE: begin
        if (change_req && !abort) begin
          start_next = limit;
          dir_next   = ~limit;
          level_next = limit ? LVL_MAX : LVL_ZERO;
          err_next   = 1'b0;
          state_next = S_RAMP;
        end
      end
      S_RAMP: begin
        if (abort) begin
          state_next = S_RETURN;
        end else begin
          level_next = dir ? level + LVL_ONE : level - LVL_ONE;
          if (level_next == ramp_end) state_next = S_PULSE;
        end
      end
      S_PULSE: begin
        ack_next   = '0;
        state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (limit != start_limit) begin
          state_next = S_IDLE;
        end else if (ack_cnt == ACK_LAST) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else begin
          ack_next = ack_cnt + ACK_ONE;
        end
      end
      S_RETURN: begin
        if (level == start_level) begin
          state_next = S_IDLE;
        end else begin
          level_next = dir ? level - LVL_ONE : level + LVL_ONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign key  = (state == S_PULSE);
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_pressure_sequencer.sv
// Directed bench for pressure_sequencer: ramps both ways, ack timeout, abort,
// held request / abort-in-idle, and asynchronous reset mid-ramp.
module tb_pressure_sequencer;

  logic       clk = 1'b0;
  logic       reset, change_req, abort, limit;
  logic       key, busy, dir, err;
  logic [3:0] level;

  int vectors = 0;
  int miscompares = 0;

  pressure_sequencer #(.RAMP_CYCLES(8), .CNT_W(4), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .change_req(change_req), .abort(abort),
    .limit(limit), .key(key), .busy(busy), .dir(dir), .level(level), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", tag, actual, expected);
    end
  endtask

  // Drive inputs, then advance to 1 time unit past the next rising edge.
  task automatic applyStimulus(input logic cr, input logic ab, input logic lim);
    change_req = cr;
    abort      = ab;
    limit      = lim;
    @(posedge clk);
    #1;
  endtask

  int keys;

  initial begin
    reset = 1'b1; change_req = 1'b0; abort = 1'b0; limit = 1'b0;
    #12;
    checkOutput("rst_level", level, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_key", key, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_dir", dir, 0);
    @(negedge clk);
    reset = 1'b0;

    // Up ramp with acknowledgement at E10
    applyStimulus(1, 0, 0);
    checkOutput("up_e0_busy", busy, 1);
    checkOutput("up_e0_dir", dir, 1);
    checkOutput("up_e0_level", level, 0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 0);
      checkOutput($sformatf("up_level_e%0d", i), level, i);
      checkOutput($sformatf("up_key_e%0d", i), key, (i == 8) ? 1 : 0);
    end
    applyStimulus(0, 0, 0);
    checkOutput("up_e9_key", key, 0);
    checkOutput("up_e9_busy", busy, 1);
    applyStimulus(0, 0, 1);
    checkOutput("up_e10_busy", busy, 0);
    checkOutput("up_e10_err", err, 0);

    // Down ramp from limit=1
    applyStimulus(1, 0, 1);
    checkOutput("dn_e0_dir", dir, 0);
    checkOutput("dn_e0_level", level, 8);
    keys = 0;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 1);
      checkOutput($sformatf("dn_level_e%0d", i), level, 8 - i);
      keys += int'(key);
    end
    checkOutput("dn_e8_key", key, 1);
    applyStimulus(0, 0, 1);
    keys += int'(key);
    checkOutput("dn_key_count", keys, 1);
    applyStimulus(0, 0, 0);
    checkOutput("dn_e10_busy", busy, 0);
    checkOutput("dn_e10_err", err, 0);

    // Ack timeout: limit stays 0 after the pulse
    applyStimulus(1, 0, 0);
    for (int i = 1; i <= 9; i++) applyStimulus(0, 0, 0);
    for (int i = 10; i <= 12; i++) begin
      applyStimulus(0, 0, 0);
      checkOutput($sformatf("to_busy_e%0d", i), busy, 1);
      checkOutput($sformatf("to_err_e%0d", i), err, 0);
    end
    applyStimulus(0, 0, 0);
    checkOutput("to_e13_err", err, 1);
    checkOutput("to_e13_busy", busy, 0);
    applyStimulus(0, 0, 0);
    checkOutput("to_err_sticky", err, 1);
    applyStimulus(1, 0, 0);
    checkOutput("to_clear_err", err, 0);
    checkOutput("to_clear_busy", busy, 1);
    for (int i = 1; i <= 9; i++) applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 1);
    checkOutput("to_done_busy", busy, 0);

    // Abort at E4 with level 3, limit back to 0 while idle
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    keys = 0;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 0);
      keys += int'(key);
    end
    checkOutput("ab_e3_level", level, 3);
    applyStimulus(0, 1, 0);
    checkOutput("ab_e4_level", level, 3);
    checkOutput("ab_e4_busy", busy, 1);
    for (int i = 5; i <= 7; i++) begin
      applyStimulus(0, 0, 1);
      checkOutput($sformatf("ab_level_e%0d", i), level, 7 - i);
      checkOutput($sformatf("ab_busy_e%0d", i), busy, 1);
      keys += int'(key);
    end
    applyStimulus(0, 0, 0);
    keys += int'(key);
    checkOutput("ab_e8_busy", busy, 0);
    checkOutput("ab_e8_level", level, 0);
    checkOutput("ab_key_count", keys, 0);

    // change_req held through a full ramp: a single pulse
    applyStimulus(1, 0, 0);
    keys = 0;
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1, 0, 0);
      keys += int'(key);
    end
    applyStimulus(1, 0, 1);
    checkOutput("hold_e10_busy", busy, 0);
    checkOutput("hold_key_count", keys, 1);
    applyStimulus(1, 1, 1);
    checkOutput("both_busy_a", busy, 0);
    applyStimulus(1, 1, 0);
    checkOutput("both_busy_b", busy, 0);
    checkOutput("both_level", level, 8);

    // Asynchronous reset mid-ramp at level 5
    applyStimulus(1, 0, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(0, 0, 0);
    checkOutput("ar_pre_level", level, 5);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_level", level, 0);
    checkOutput("ar_busy", busy, 0);
    checkOutput("ar_key", key, 0);
    checkOutput("ar_err", err, 0);
    checkOutput("ar_dir", dir, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 0, 0);
    checkOutput("ar_post_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pressure_sequencer.md
Name: pressure_sequencer

Overview:
Drives pressure changes in the chamber controller and produces the toggle key consumed by the limit_pressure block.
- On an accepted change request, it ramps a modelled chamber pressure level over RAMP_CYCLES clocks, up or down depending on the current limit state.
- At the end of the ramp it issues a single-cycle key pulse, then waits for limit to toggle as acknowledgement.
- Supports mid-ramp abort (return to start level, no pulse) and reports a sticky error if the acknowledgement never arrives.

Parameters:
RAMP_CYCLES, 8, number of clock edges to move level between 0 and RAMP_CYCLES (min 1).
CNT_W, 4, width of level; must hold the value RAMP_CYCLES.
ACK_TIMEOUT, 4, number of WAIT_ACK cycles allowed for limit to toggle before err is set (min 2).

Ports:
clk  input  1  single system clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
change_req  input  1  request a pressure change; sampled only in IDLE.
abort  input  1  cancel an in-progress ramp; sampled only in RAMP.
limit  input  1  current limit state from limit_pressure: 0 = WITHIN, 1 = BEYOND.
key  output  1  one-cycle toggle pulse to limit_pressure.
busy  output  1  high in every state except IDLE.
dir  output  1  ramp direction: 1 = up (toward RAMP_CYCLES), 0 = down (toward 0).
level  output  CNT_W  modelled chamber pressure level, 0..RAMP_CYCLES.
err  output  1  sticky acknowledgement-timeout flag.

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - key=0, busy=0, dir=0, level=0, err=0.
  - Internal start_limit=0, ack counter=0.
- All outputs are registered or Moore-decoded from state; none depends combinationally on any input.
- States: IDLE, RAMP, PULSE, WAIT_ACK, RETURN.
- IDLE, on an edge with change_req=1 and abort=0 (accept):
  - start_limit <= limit.
  - dir <= ~limit.
  - level <= 0 if limit=0, RAMP_CYCLES if limit=1.
  - err <= 0.
  - Next state RAMP.
  - change_req=1 together with abort=1 in IDLE: not accepted; stay IDLE.
- RAMP:
  - Each edge, level steps by 1 in direction dir.
  - On the edge where level becomes the end value (RAMP_CYCLES if dir=1, 0 if dir=0), next state is PULSE.
  - abort=1 at an edge has priority over stepping: level is held, next state RETURN.
  - change_req is ignored while busy.
- PULSE: key=1 for exactly this one cycle; next state WAIT_ACK; level holds.
- WAIT_ACK:
  - If limit != start_limit at an edge: next state IDLE, no error.
  - Otherwise the ack counter increments; on the ACK_TIMEOUT-th failing edge, err <= 1 and next state IDLE.
  - The ack counter clears on entry to WAIT_ACK.
  - A limit toggle arriving 1 or 2 edges after the key pulse must be accepted.
- RETURN:
  - Each edge, level steps opposite to dir.
  - When level equals the start value (0 if start_limit=0, RAMP_CYCLES if start_limit=1), next state IDLE. This is checked before stepping, so an abort on the first RAMP edge returns to IDLE on the next edge.
  - No key pulse is issued on the abort path.
  - abort and change_req are ignored in RETURN.
- Latency, accept at edge E0:
  - level reaches its end value at edge E_R, R = RAMP_CYCLES.
  - key is high between edges E_R and E_R+1.
  - busy is high from E0 through the edge that returns to IDLE.
- Boundaries:
  - level never leaves 0..RAMP_CYCLES.
  - err persists through IDLE until the next accepted request or reset.
  - Reset mid-operation aborts immediately; no pulse is emitted.
  - A limit change outside WAIT_ACK is ignored.
  - RAMP_CYCLES=1 gives a single-step ramp followed directly by PULSE.

Test Plan:
- Reset, limit=0, change_req pulse at E0 -> busy=1; dir=1; level 1..8 at E1..E8; key=1 only between E8 and E9; limit toggled to 1 at E10 -> busy=0 at E10, err=0.
- limit=1, change_req at E0 -> dir=0; level 8 at E0, counting down to 0 at E8; single key pulse; limit toggle to 0 returns to IDLE.
- limit held constant after key -> err=1 after 4 WAIT_ACK edges, state IDLE; next accepted change_req clears err to 0.
- limit=0, change_req at E0, abort at E4 (level=3) -> level 3,2,1,0 over the following edges; IDLE after level reaches 0; key never asserted.
- change_req held high throughout a ramp -> only one pulse per accepted request; change_req and abort together in IDLE -> no accept, busy stays 0.
- Assert reset asynchronously mid-RAMP at level=5 -> outputs return immediately to level=0, busy=0, key=0, err=0.
